// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT stage scaler.
//   DATA_WIDTH     default sample width (Q1.31)
//   sample_t       signed sample type
//   scaler_state_e FILL / DRAIN frame states
//   asr1           divide-by-two helper; truncating by default, half-up
//                  rounding when FFT_SCALER_ROUND_EN is defined.
package fft_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } scaler_state_e;

    // One-bit arithmetic right shift. The rounding variant works one bit wider
    // so the +1 cannot wrap; dropping the LSB always brings it back in range.
    function automatic sample_t asr1(input sample_t x);
`ifdef FFT_SCALER_ROUND_EN
        logic [DATA_WIDTH:0] ext;
        ext = {x[DATA_WIDTH-1], x} + (DATA_WIDTH+1)'(1);
        return ext[DATA_WIDTH:1];
`else
        return {x[DATA_WIDTH-1], x[DATA_WIDTH-1:1]};
`endif
    endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// fft_frame_ram: single-port frame buffer, one word per sample (data + ovf).
//   clk_i  clock
//   we     write enable (synchronous write of wdata to addr)
//   re     read enable (rdata registers mem[addr]; holds when re = 0)
//   addr   shared read/write address
//   wdata  write word
//   rdata  registered read word
module fft_frame_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 33,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/fft_stage_scaler.sv
// fft_stage_scaler: buffers one FFT stage frame of butterfly sums and, when
// any sample of the frame overflowed (and was halved by the adder), halves
// every other sample too so the frame shares one block-floating-point scale.
// Build option: FFT_SCALER_ROUND_EN selects half-up rounding for the shift.
//   clk_i, rst_i  clock, synchronous active-high reset
//   sum_i/ovf_i   adder sample and its overflow flag, qualified by valid_i
//   ready_o       high while filling a frame (registered, no path from ready_i)
//   data_o/valid_o/last_o  frame-consistent output stream, ready_i handshake
//   scale_o       1 when the frame being drained was scaled by 1/2
//   ovf_cnt_o     overflowed-sample count of the frame being drained
// Handshake: a word moves on a rising edge only when its valid and ready are
// both 1; while valid is high and ready low, the word and its flags hold.
module fft_stage_scaler #(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int FRAME_LEN  = 64,
    parameter int CNT_W      = $clog2(FRAME_LEN+1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] sum_i,
    input  logic                  ovf_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  scale_o,
    output logic [CNT_W-1:0]      ovf_cnt_o
);
    import fft_pkg::*;

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN-1);

    scaler_state_e state_q, state_d;

    logic [IDX_W-1:0]      wr_idx, rd_idx, ram_addr;
    logic                  rd_done;
    logic                  frame_ovf;
    logic [CNT_W-1:0]      acc_cnt, cnt_q;
    logic                  ready_q, scale_q;
    logic                  q_vld, q_last;
    logic                  out_vld, out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH:0]   ram_rdata;
    logic [DATA_WIDTH-1:0] q_data, scaled;
    logic                  q_ovf;
    logic                  accept, advance, rd_issue, out_xfer;

    assign accept   = valid_i && ready_q && (state_q == FILL);
    // The read stage and output register move together; the RAM read is
    // gated so its registered output also holds during a stall.
    assign advance  = !out_vld || ready_i;
    assign rd_issue = (state_q == DRAIN) && advance && !rd_done;
    assign out_xfer = out_vld && ready_i;
    assign ram_addr = (state_q == FILL) ? wr_idx : rd_idx;

    assign q_data = ram_rdata[DATA_WIDTH-1:0];
    assign q_ovf  = ram_rdata[DATA_WIDTH];
    assign scaled = (scale_q && !q_ovf) ? asr1(q_data) : q_data;

    fft_frame_ram #(
        .DEPTH (FRAME_LEN),
        .WIDTH (DATA_WIDTH+1)
    ) u_ram (
        .clk_i (clk_i),
        .we    (accept),
        .re    (rd_issue),
        .addr  (ram_addr),
        .wdata ({ovf_i, sum_i}),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && (wr_idx == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (out_xfer && out_last)           state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FILL;
            ready_q   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            rd_done   <= 1'b0;
            frame_ovf <= 1'b0;
            acc_cnt   <= '0;
            cnt_q     <= '0;
            scale_q   <= 1'b0;
            q_vld     <= 1'b0;
            q_last    <= 1'b0;
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == FILL);

            if (accept) begin
                wr_idx <= wr_idx + IDX_W'(1);
                if (wr_idx == LAST_IDX) begin
                    scale_q   <= frame_ovf | ovf_i;
                    cnt_q     <= acc_cnt + CNT_W'(ovf_i);
                    frame_ovf <= 1'b0;
                    acc_cnt   <= '0;
                end else begin
                    frame_ovf <= frame_ovf | ovf_i;
                    acc_cnt   <= acc_cnt + CNT_W'(ovf_i);
                end
            end

            if (advance) begin
                q_vld    <= rd_issue;
                out_vld  <= q_vld;
                out_last <= q_vld && q_last;
                if (q_vld) begin
                    out_data <= scaled;
                end
            end

            if (rd_issue) begin
                rd_idx <= rd_idx + IDX_W'(1);
                q_last <= (rd_idx == LAST_IDX);
                if (rd_idx == LAST_IDX) begin
                    rd_done <= 1'b1;
                end
            end

            if (out_xfer && out_last) begin
                rd_done <= 1'b0;
                rd_idx  <= '0;
                scale_q <= 1'b0;
                cnt_q   <= '0;
            end
        end
    end

    assign ready_o   = ready_q;
    assign data_o    = out_data;
    assign valid_o   = out_vld;
    assign last_o    = out_last;
    assign scale_o   = scale_q;
    assign ovf_cnt_o = cnt_q;

endmodule

// File: tb/tb_fft_stage_scaler.sv
// tb_fft_stage_scaler: directed bench for fft_stage_scaler. Two instances
// (FRAME_LEN 4 and 64) share sum/ovf/ready; sel chooses which one is driven
// and observed. Expected values come from hand-written vectors and a small
// reference shift.
module tb_fft_stage_scaler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sum_i = '0;
    logic        ovf_i = 1'b0;
    logic        vin = 1'b0;
    logic        ready_i = 1'b1;
    logic        sel = 1'b0;

    logic        ready4, valid4, last4, scale4;
    logic [31:0] data4;
    logic [2:0]  cnt4;
    logic        ready64, valid64, last64, scale64;
    logic [31:0] data64;
    logic [6:0]  cnt64;

    logic        rdy_o, v_o, l_o, s_o;
    logic [31:0] d_o;
    logic [7:0]  c_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fft_stage_scaler #(.DATA_WIDTH(32), .FRAME_LEN(4)) u4 (
        .clk_i(clk), .rst_i(rst), .sum_i(sum_i), .ovf_i(ovf_i),
        .valid_i(vin && !sel), .ready_o(ready4), .data_o(data4),
        .valid_o(valid4), .ready_i(ready_i), .last_o(last4),
        .scale_o(scale4), .ovf_cnt_o(cnt4)
    );

    fft_stage_scaler #(.DATA_WIDTH(32), .FRAME_LEN(64)) u64 (
        .clk_i(clk), .rst_i(rst), .sum_i(sum_i), .ovf_i(ovf_i),
        .valid_i(vin && sel), .ready_o(ready64), .data_o(data64),
        .valid_o(valid64), .ready_i(ready_i), .last_o(last64),
        .scale_o(scale64), .ovf_cnt_o(cnt64)
    );

    assign rdy_o = sel ? ready64 : ready4;
    assign v_o   = sel ? valid64 : valid4;
    assign l_o   = sel ? last64  : last4;
    assign s_o   = sel ? scale64 : scale4;
    assign d_o   = sel ? data64  : data4;
    assign c_o   = sel ? {1'b0, cnt64} : {5'b0, cnt4};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_half(input logic [31:0] d);
        logic signed [32:0] w;
`ifdef FFT_SCALER_ROUND_EN
        w = $signed({d[31], d}) + 33'sd1;
`else
        w = $signed({d[31], d});
`endif
        w = w >>> 1;
        return w[31:0];
    endfunction

    // Offer one sample and wait (bounded) until it has been accepted.
    task automatic push(input logic [31:0] d, input logic o);
        int cyc = 0;
        sum_i = d;
        ovf_i = o;
        vin   = 1'b1;
        while (!rdy_o && cyc < 300) begin
            tick();
            cyc++;
        end
        if (!rdy_o) check("push_timeout", 64'(cyc), 64'd0);
        tick();
        vin = 1'b0;
    endtask

    // Drain exp_q. rp/rp_len give the ready_i pattern applied from the first
    // cycle valid_o is seen; ready_i is 1 once the pattern is used up.
    task automatic drain(input logic [7:0] rp, input int rp_len,
                         input logic exp_scale, input logic [7:0] exp_cnt);
        int k = 0;
        int cyc = 0;
        logic r;
        logic stalled = 1'b0;
        logic [31:0] hold_d = '0;
        logic [31:0] e;
        while (exp_q.size() > 0 && cyc < 400) begin
            if (stalled) check("stall_valid", 64'(v_o), 64'd1);
            if (v_o) begin
                r = (k < rp_len && k < 8) ? rp[k] : 1'b1;
                k++;
                if (stalled) check("stall_data", 64'(d_o), 64'(hold_d));
                check("drain_ready_o", 64'(rdy_o), 64'd0);
                check("drain_scale", 64'(s_o), 64'(exp_scale));
                check("drain_cnt", 64'(c_o), 64'(exp_cnt));
                ready_i = r;
                if (r) begin
                    e = exp_q.pop_front();
                    check("drain_data", 64'(d_o), 64'(e));
                    check("drain_last", 64'(l_o), 64'(exp_q.size() == 0));
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d  = d_o;
                end
            end else begin
                ready_i = 1'b1;
            end
            tick();
            cyc++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        ready_i = 1'b1;
        check("post_ready_o", 64'(rdy_o), 64'd1);
        check("post_valid_o", 64'(v_o), 64'd0);
    endtask

    initial begin
        logic [31:0] d1[4];
        logic [31:0] d2[4];
        logic [31:0] d;

        // Reset state on both instances.
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check("rst_ready", 64'(rdy_o), 64'd0);
            check("rst_valid", 64'(v_o), 64'd0);
            check("rst_misc", {29'd0, l_o, s_o, 3'd0, c_o, d_o}, 64'd0);
        end
        sel = 1'b0;
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(rdy_o), 64'd1);

        // Test 1: clean frame, passthrough, valid latency of 2 cycles.
        d1 = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
        for (int i = 0; i < 4; i++) push(d1[i], 1'b0);
        check("t1_valid_e0", 64'(v_o), 64'd0);
        check("t1_ready_e0", 64'(rdy_o), 64'd0);
        tick();
        check("t1_valid_e1", 64'(v_o), 64'd0);
        tick();
        check("t1_valid_e2", 64'(v_o), 64'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(d1[i]);
        drain(8'hFF, 0, 1'b0, 8'd0);

        // Test 2: one overflowed sample forces the rest to be halved.
        d2 = '{32'h1000_0000, 32'h6000_0000, 32'hF000_0000, 32'h0000_0003};
        push(d2[0], 1'b0);
        push(d2[1], 1'b1);
        push(d2[2], 1'b0);
        push(d2[3], 1'b0);
        exp_q.push_back(32'h0800_0000);
        exp_q.push_back(32'h6000_0000);
        exp_q.push_back(32'hF800_0000);
`ifdef FFT_SCALER_ROUND_EN
        exp_q.push_back(32'h0000_0002);
`else
        exp_q.push_back(32'h0000_0001);
`endif
        drain(8'hFF, 0, 1'b1, 8'd1);

        // Test 3: every sample overflowed, data unchanged.
        for (int i = 0; i < 4; i++) push(32'hC000_0000, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hC000_0000);
        drain(8'hFF, 0, 1'b1, 8'd4);

        // Test 4: stalled drain with ready pattern 1,0,0,1,0,1,1; mixed
        // boundary values including the most negative and -1.
        push(32'h8000_0000, 1'b0);
        push(32'hFFFF_FFFF, 1'b0);
        push(32'h7FFF_FFFF, 1'b1);
        push(32'h0000_0005, 1'b0);
        exp_q.push_back(32'hC000_0000);
`ifdef FFT_SCALER_ROUND_EN
        exp_q.push_back(32'h0000_0000);
`else
        exp_q.push_back(32'hFFFF_FFFF);
`endif
        exp_q.push_back(32'h7FFF_FFFF);
`ifdef FFT_SCALER_ROUND_EN
        exp_q.push_back(32'h0000_0003);
`else
        exp_q.push_back(32'h0000_0002);
`endif
        drain(8'h69, 7, 1'b1, 8'd1);

        // Test 5: reset after two overflowed accepts discards the partial frame.
        push(32'h7000_0000, 1'b1);
        push(32'h7000_0000, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        check("t5_rst_ready", 64'(rdy_o), 64'd0);
        check("t5_rst_misc", {29'd0, v_o, l_o, s_o, c_o, d_o}, 64'd0);
        rst = 1'b0;
        tick();
        check("t5_ready", 64'(rdy_o), 64'd1);
        for (int i = 0; i < 4; i++) push(32'h0000_0011 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0011 + 32'(i));
        drain(8'hFF, 0, 1'b0, 8'd0);

        // Test 6: FRAME_LEN 64, ovf on sample 63 only, valid_i held high
        // during the drain must not capture anything.
        sel = 1'b1;
        #0;
        check("t6_ready", 64'(rdy_o), 64'd1);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) begin
                d = (32'h0123_4567 * 32'(i + 1)) ^ (f != 0 ? 32'hFFFF_0000 : 32'h0);
                push(d, i == 63);
                exp_q.push_back(i == 63 ? d : ref_half(d));
            end
            sum_i = 32'hDEAD_BEEF;
            ovf_i = 1'b1;
            vin   = 1'b1;
            drain(8'hFF, 0, 1'b1, 8'd1);
            vin   = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_stage_scaler.md
Name: fft_stage_scaler

Overview:
- Sits directly downstream of the FFT butterfly adder.
- The adder halves any sample whose Q1.31 sum overflowed and flags it. That leaves mixed scaling inside one FFT stage frame.
- This block buffers one frame of adder outputs together with their overflow flags. If any sample in the frame overflowed, it right-shifts every non-overflowed sample by one, so the whole frame shares a single scale.
- It reports the per-frame scale bit (block-floating-point exponent increment) to the next stage.

Parameters:
- DATA_WIDTH, 32, sample width, Q1.31 two's complement.
- FRAME_LEN, 64, samples per frame; power of two, minimum 2.
- CNT_W, $clog2(FRAME_LEN+1), width of the overflow counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- sum_i  in  DATA_WIDTH  adder sum output, Q1.31.
- ovf_i  in  1  adder overflow flag for sum_i; when 1, sum_i is already halved.
- valid_i  in  1  sum_i/ovf_i valid.
- ready_o  out  1  block can accept a sample.
- data_o  out  DATA_WIDTH  frame-consistent sample, Q1.31.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts data_o.
- last_o  out  1  marks the final sample of a frame on data_o.
- scale_o  out  1  1 when the current output frame was scaled by 1/2; constant for the whole frame.
- ovf_cnt_o  out  CNT_W  number of overflowed samples in the frame currently being drained.

Behaviour:
- Reset values:
  - state = FILL; write/read indices = 0.
  - ready_o = 0 during reset, 1 from the first cycle after reset.
  - valid_o, last_o, scale_o = 0; ovf_cnt_o = 0; data_o = 0.
- Transfers occur only when valid and ready are both 1 on a rising edge. No combinational path from ready_i to ready_o.
- State FILL:
  - ready_o = 1 and valid_o = 0.
  - Each accepted sample is written to buffer[wr_idx] together with its ovf_i bit.
  - frame_ovf |= ovf_i; the overflow count increments when ovf_i = 1.
  - wr_idx increments per accept.
  - When the accept with wr_idx = FRAME_LEN-1 occurs: go to DRAIN, latch frame_ovf into scale_o and the count into ovf_cnt_o, then clear the accumulators.
- State DRAIN:
  - ready_o = 0. valid_o rises exactly 2 cycles after the final-sample acceptance edge (1 cycle state change, 1 cycle registered RAM read).
  - Samples are output in write order, index 0 to FRAME_LEN-1.
  - data_o = buffer[i] when scale_o = 0 or ovf[i] = 1; otherwise buffer[i] >>> 1 (arithmetic, sign preserved, truncation).
  - When ready_i = 0, data_o, valid_o and last_o hold stable. Back-to-back transfers sustain 1 sample per cycle when ready_i stays high.
  - last_o = 1 with index FRAME_LEN-1. The transfer of that sample returns the block to FILL; ready_o = 1 in the next cycle.
  - scale_o and ovf_cnt_o stay valid until that last transfer.
- Arithmetic and boundaries:
  - Shift never overflows. 0x80000000 >>> 1 = 0xC0000000; 0xFFFFFFFF >>> 1 = 0xFFFFFFFF.
  - All samples overflowed: scale_o = 1 and data passes unchanged.
- Frame boundaries are defined purely by the sample count since reset. There is no start-of-frame input.
- valid_i asserted while ready_o = 0 is ignored; the sample is not captured.
- Reset mid-frame or mid-drain: partial frame discarded, outputs go to reset values. Buffer contents are don't-care.
- ready_i toggling every cycle during DRAIN: no sample is lost or duplicated.

Optional Feature:
- Macro: FFT_SCALER_ROUND_EN.
- Defined: the applied shift rounds half-up, data_o = (sign-extended buffer[i] + 1) >>> 1 computed at DATA_WIDTH+1 bits and truncated to DATA_WIDTH. The result always fits; no saturation is needed. Example: 0x00000003 gives 0x00000002; 0xFFFFFFFF gives 0x00000000.
- Undefined: truncating arithmetic shift only. Example: 0x00000003 gives 0x00000001.
- Unshifted samples are identical in both builds.

Decomposition:
- fft_pkg holds:
  - DATA_WIDTH default constant;
  - sample_t (logic signed [DATA_WIDTH-1:0]);
  - scaler_state_e {FILL, DRAIN};
  - function asr1 (truncating or rounding variant, selected by the macro).
- One sub-module: fft_frame_ram.
  - Single-port FRAME_LEN x (DATA_WIDTH+1) memory (sample plus ovf bit).
  - Synchronous write, registered read.
  - Single-port is sufficient because FILL and DRAIN are exclusive.

Test Plan (FRAME_LEN=4 unless stated):
- Frame {0x10000000, 0x20000000, 0x30000000, 0x40000000}, all ovf=0, ready_i=1 → identical data out, scale_o=0, ovf_cnt_o=0, last_o on 4th sample, valid_o 2 cycles after 4th accept.
- Frame {0x10000000(ovf=0), 0x60000000(ovf=1), 0xF0000000(ovf=0), 0x00000003(ovf=0)} → {0x08000000, 0x60000000, 0xF8000000, 0x00000001}, scale_o=1, ovf_cnt_o=1. With FFT_SCALER_ROUND_EN the last sample is 0x00000002.
- All four ovf=1 with data 0xC0000000 → data unchanged, scale_o=1, ovf_cnt_o=4.
- Drain with ready_i pattern 1,0,0,1,0,1,1 → exactly 4 transfers in order, outputs stable while stalled, ready_o=0 throughout, then ready_o=1.
- rst_i pulsed after 2 accepts, then a full clean frame → only the clean frame is output; scale_o reflects only that frame.
- valid_i held high during DRAIN with FRAME_LEN=64, ovf=1 on sample 63 only → those inputs are not captured, and in the next frame samples 0..62 are shifted while sample 63 passes unchanged.
